// File: rtl/sram_array_ctrl_if.sv
// Request/response bus and phase strobes between a master and sram_array_ctrl.
interface sram_array_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              precharge;
  logic [DEPTH-1:0]  wl;
  logic              sense_en;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, precharge, wl, sense_en
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, precharge, wl, sense_en
  );
endinterface

// File: rtl/sram_array_ctrl.sv
// Behavioural SRAM array with a precharge / word-line / sense access sequencer,
// per-bit write mask and out-of-range detection.
module sram_array_ctrl #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int WL_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_array_ctrl_if.slave  bus
);

  localparam int              CNT_W   = (WL_CYCLES > 1) ? $clog2(WL_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WL, S_SENSE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wmask;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_precharge;
  logic              r_sense;
  logic [DEPTH-1:0]  r_wl;

  logic              w_in_range;
  logic              w_wl_last;
  logic              w_wr_en;
  logic [DEPTH-1:0]  w_wl_dec;
  logic [DATA_W-1:0] w_rd_word;

  assign w_in_range = {1'b0, r_addr} < DEPTH_C;
  assign w_wl_last  = (r_cnt == CNT_W'(WL_CYCLES - 1));
  assign w_wr_en    = (r_state == S_WL) && w_wl_last && r_we;

  // An out-of-range address matches no word, so it decodes to no word line and reads zero.
  always_comb begin
    w_wl_dec  = '0;
    w_rd_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_addr == ADDR_W'(i)) begin
        w_wl_dec[i] = 1'b1;
        w_rd_word   = r_mem[i];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = S_PRE;
      S_PRE:   w_next = S_WL;
      S_WL:    if (w_wl_last) w_next = r_we ? S_RESP : S_SENSE;
      S_SENSE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Strobes are registered from the next state so every output is a flop with no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_precharge <= 1'b0;
      r_sense     <= 1'b0;
      r_wl        <= '0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wmask <= bus.req_wmask;
      end
      r_cnt <= (r_state == S_WL && !w_wl_last) ? r_cnt + 1'b1 : '0;
      if (r_state == S_SENSE) r_rdata <= w_rd_word;
      r_ready     <= (w_next == S_IDLE);
      r_precharge <= (w_next == S_PRE);
      r_sense     <= (w_next == S_SENSE);
      r_rsp_valid <= (w_next == S_RESP);
      r_rsp_err   <= (w_next == S_RESP) && !w_in_range;
      r_wl        <= (w_next == S_WL) ? w_wl_dec : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_addr == ADDR_W'(i)) r_mem[i] <= (r_mem[i] & ~r_wmask) | (r_wdata & r_wmask);
      end
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.precharge = r_precharge;
  assign bus.sense_en  = r_sense;
  assign bus.wl        = r_wl;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl: three instances (WL_CYCLES 2/1/4, DEPTH 16/12/12)
// exercised one at a time through a shared stimulus and an output mux.
module tb_sram_array_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int sel = 0;
  int cur_l = 2;
  int cur_d = 16;

  logic       tb_valid = 1'b0;
  logic       tb_we = 1'b0;
  logic [3:0] tb_addr = '0;
  logic [7:0] tb_wdata = '0;
  logic [7:0] tb_wmask = '0;

  sram_array_ctrl_if #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) if0 ();
  sram_array_ctrl_if #(.DATA_W(8), .DEPTH(12), .ADDR_W(4)) if1 ();
  sram_array_ctrl_if #(.DATA_W(8), .DEPTH(12), .ADDR_W(4)) if2 ();

  sram_array_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .WL_CYCLES(2))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sram_array_ctrl #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .WL_CYCLES(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sram_array_ctrl #(.DATA_W(8), .DEPTH(12), .ADDR_W(4), .WL_CYCLES(4))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.req_valid = tb_valid && (sel == 0);
  assign if1.req_valid = tb_valid && (sel == 1);
  assign if2.req_valid = tb_valid && (sel == 2);
  assign if0.req_we = tb_we;     assign if1.req_we = tb_we;     assign if2.req_we = tb_we;
  assign if0.req_addr = tb_addr; assign if1.req_addr = tb_addr; assign if2.req_addr = tb_addr;
  assign if0.req_wdata = tb_wdata; assign if1.req_wdata = tb_wdata; assign if2.req_wdata = tb_wdata;
  assign if0.req_wmask = tb_wmask; assign if1.req_wmask = tb_wmask; assign if2.req_wmask = tb_wmask;

  logic        m_ready, m_rsp_valid, m_err, m_pre, m_sense;
  logic [7:0]  m_rdata;
  logic [15:0] m_wl;

  always_comb begin
    case (sel)
      1: begin
        m_ready = if1.req_ready; m_rsp_valid = if1.rsp_valid; m_err = if1.rsp_err;
        m_pre = if1.precharge; m_sense = if1.sense_en; m_rdata = if1.rsp_rdata; m_wl = 16'(if1.wl);
      end
      2: begin
        m_ready = if2.req_ready; m_rsp_valid = if2.rsp_valid; m_err = if2.rsp_err;
        m_pre = if2.precharge; m_sense = if2.sense_en; m_rdata = if2.rsp_rdata; m_wl = 16'(if2.wl);
      end
      default: begin
        m_ready = if0.req_ready; m_rsp_valid = if0.rsp_valid; m_err = if0.rsp_err;
        m_pre = if0.precharge; m_sense = if0.sense_en; m_rdata = if0.rsp_rdata; m_wl = if0.wl;
      end
    endcase
  end

  // Per-access observations, cycle 1 being the cycle after the handshake edge.
  int          st_ready_ok, st_pre_first, st_pre_cnt, st_wl_first, st_wl_cnt;
  int          st_sense_first, st_sense_cnt, st_rsp_cyc, st_overlap, st_busy_ready;
  logic [15:0] st_wl_or;
  logic [7:0]  st_rdata;
  logic        st_err;

  task automatic do_access(input logic we, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] wm);
    @(negedge clk);
    tb_we = we; tb_addr = a; tb_wdata = wd; tb_wmask = wm; tb_valid = 1'b1;
    st_ready_ok = int'(m_ready);
    st_pre_first = -1; st_pre_cnt = 0; st_wl_first = -1; st_wl_cnt = 0;
    st_sense_first = -1; st_sense_cnt = 0; st_rsp_cyc = -1; st_overlap = 0;
    st_busy_ready = 0; st_wl_or = '0; st_rdata = 'x; st_err = 1'bx;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tb_valid = 1'b0;
      if (m_pre) begin if (st_pre_first < 0) st_pre_first = c; st_pre_cnt++; end
      if (m_wl != '0) begin if (st_wl_first < 0) st_wl_first = c; st_wl_cnt++; end
      if (m_sense) begin if (st_sense_first < 0) st_sense_first = c; st_sense_cnt++; end
      st_wl_or = st_wl_or | m_wl;
      if (int'(m_pre) + int'(m_sense) + $countones(m_wl) > 1) st_overlap++;
      if (m_ready) st_busy_ready++;
      if (m_rsp_valid) begin
        st_rsp_cyc = c; st_rdata = m_rdata; st_err = m_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rst_ready sel=%0d got %b exp 1", sel, m_ready); end
    checks++; if ({m_rsp_valid, m_err, m_pre, m_sense} !== 4'b0000) begin errors++;
      $display("FAIL rst_strobes sel=%0d got %b exp 0000", sel, {m_rsp_valid, m_err, m_pre, m_sense}); end
    checks++; if (m_wl !== 16'h0000) begin errors++; $display("FAIL rst_wl sel=%0d got %h exp 0000", sel, m_wl); end
    checks++; if (m_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata sel=%0d got %h exp 00", sel, m_rdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_timing();
    do_access(1'b0, 4'd3, 8'h00, 8'h00);
    checks++; if (st_ready_ok !== 1) begin errors++; $display("FAIL rt_ready sel=%0d got %0d exp 1", sel, st_ready_ok); end
    checks++; if (st_pre_first !== 1 || st_pre_cnt !== 1) begin errors++;
      $display("FAIL rt_pre sel=%0d got first=%0d cnt=%0d exp first=1 cnt=1", sel, st_pre_first, st_pre_cnt); end
    checks++; if (st_wl_first !== 2 || st_wl_cnt !== cur_l || st_wl_or !== 16'h0008) begin errors++;
      $display("FAIL rt_wl sel=%0d got first=%0d cnt=%0d or=%h exp first=2 cnt=%0d or=0008",
               sel, st_wl_first, st_wl_cnt, st_wl_or, cur_l); end
    checks++; if (st_sense_first !== cur_l + 2 || st_sense_cnt !== 1) begin errors++;
      $display("FAIL rt_sense sel=%0d got first=%0d cnt=%0d exp first=%0d cnt=1", sel, st_sense_first, st_sense_cnt, cur_l + 2); end
    checks++; if (st_rsp_cyc !== cur_l + 3) begin errors++; $display("FAIL rt_rsp_cyc sel=%0d got %0d exp %0d", sel, st_rsp_cyc, cur_l + 3); end
    checks++; if (st_rdata !== 8'h00 || st_err !== 1'b0) begin errors++;
      $display("FAIL rt_data sel=%0d got rdata=%h err=%b exp 00/0", sel, st_rdata, st_err); end
    checks++; if (st_overlap !== 0 || st_busy_ready !== 0) begin errors++;
      $display("FAIL rt_excl sel=%0d got overlap=%0d ready_busy=%0d exp 0/0", sel, st_overlap, st_busy_ready); end
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rt_ready_back sel=%0d got %b exp 1", sel, m_ready); end
  endtask

  task automatic test_write_read();
    do_access(1'b1, 4'd7, 8'hA5, 8'hFF);
    checks++; if (st_rsp_cyc !== cur_l + 2 || st_sense_cnt !== 0 || st_err !== 1'b0) begin errors++;
      $display("FAIL wr_rsp sel=%0d got cyc=%0d sense=%0d err=%b exp cyc=%0d sense=0 err=0",
               sel, st_rsp_cyc, st_sense_cnt, st_err, cur_l + 2); end
    checks++; if (st_wl_or !== 16'h0080 || st_wl_cnt !== cur_l) begin errors++;
      $display("FAIL wr_wl sel=%0d got or=%h cnt=%0d exp 0080/%0d", sel, st_wl_or, st_wl_cnt, cur_l); end
    do_access(1'b0, 4'd7, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rd7 sel=%0d got %h exp a5", sel, st_rdata); end
    do_access(1'b0, 4'd6, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'h00) begin errors++; $display("FAIL wr_rd6 sel=%0d got %h exp 00", sel, st_rdata); end
  endtask

  task automatic test_masked();
    do_access(1'b1, 4'd2, 8'hFF, 8'hFF);
    do_access(1'b1, 4'd2, 8'h00, 8'h0F);
    do_access(1'b0, 4'd2, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'hF0) begin errors++; $display("FAIL mask_0f sel=%0d got %h exp f0", sel, st_rdata); end
    do_access(1'b1, 4'd2, 8'hAA, 8'h00);
    checks++; if (st_rsp_cyc !== cur_l + 2) begin errors++; $display("FAIL mask_00_rsp sel=%0d got %0d exp %0d", sel, st_rsp_cyc, cur_l + 2); end
    do_access(1'b0, 4'd2, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'hF0) begin errors++; $display("FAIL mask_00 sel=%0d got %h exp f0", sel, st_rdata); end
  endtask

  task automatic test_out_of_range();
    do_access(1'b1, 4'd13, 8'h5A, 8'hFF);
    checks++; if (st_err !== 1'b1 || st_rsp_cyc !== cur_l + 2) begin errors++;
      $display("FAIL oor_wr sel=%0d got err=%b cyc=%0d exp 1/%0d", sel, st_err, st_rsp_cyc, cur_l + 2); end
    checks++; if (st_wl_or !== 16'h0000 || st_pre_cnt !== 1) begin errors++;
      $display("FAIL oor_wr_wl sel=%0d got wl_or=%h pre=%0d exp 0000/1", sel, st_wl_or, st_pre_cnt); end
    do_access(1'b0, 4'd13, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'h00 || st_err !== 1'b1 || st_rsp_cyc !== cur_l + 3) begin errors++;
      $display("FAIL oor_rd sel=%0d got rdata=%h err=%b cyc=%0d exp 00/1/%0d", sel, st_rdata, st_err, st_rsp_cyc, cur_l + 3); end
    checks++; if (st_sense_first !== cur_l + 2 || st_wl_or !== 16'h0000) begin errors++;
      $display("FAIL oor_rd_seq sel=%0d got sense=%0d wl_or=%h exp %0d/0000", sel, st_sense_first, st_wl_or, cur_l + 2); end
    do_access(1'b0, 4'd5, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'h00 || st_err !== 1'b0) begin errors++;
      $display("FAIL oor_alias5 sel=%0d got %h/%b exp 00/0", sel, st_rdata, st_err); end
    do_access(1'b0, 4'd7, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'hA5) begin errors++; $display("FAIL oor_keep7 sel=%0d got %h exp a5", sel, st_rdata); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0, rsps = 0, busy = 0, viol = 0, bad = 0;
    @(negedge clk);
    tb_we = 1'b0; tb_addr = 4'd7; tb_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (accepts == 3) tb_valid = 1'b0;
      if (busy > 0) begin if (m_ready) viol++; busy--; end
      if (m_rsp_valid) begin rsps++; if (m_rdata !== 8'hA5) bad++; end
      if (m_ready && tb_valid) begin accepts++; busy = cur_l + 3; end
      if (rsps == 3 && busy == 0) break;
      @(negedge clk);
    end
    tb_valid = 1'b0;
    checks++; if (accepts !== 3 || rsps !== 3) begin errors++;
      $display("FAIL b2b_count sel=%0d got acc=%0d rsp=%0d exp 3/3", sel, accepts, rsps); end
    checks++; if (viol !== 0 || bad !== 0) begin errors++;
      $display("FAIL b2b_busy sel=%0d got ready_busy=%0d bad_data=%0d exp 0/0", sel, viol, bad); end
  endtask

  task automatic test_reset_mid_access();
    int pulses = 0;
    do_access(1'b1, 4'd1, 8'h55, 8'hFF);
    do_access(1'b0, 4'd1, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'h55) begin errors++; $display("FAIL rm_pre sel=%0d got %h exp 55", sel, st_rdata); end
    @(negedge clk);
    tb_we = 1'b1; tb_addr = 4'd1; tb_wdata = 8'h3C; tb_wmask = 8'hFF; tb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (m_ready !== 1'b1 || m_wl !== 16'h0000 || m_rdata !== 8'h00) begin errors++;
      $display("FAIL rm_async sel=%0d got ready=%b wl=%h rdata=%h exp 1/0000/00", sel, m_ready, m_wl, m_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_rsp_valid) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rm_no_rsp sel=%0d got %0d exp 0", sel, pulses); end
    do_access(1'b0, 4'd1, 8'h00, 8'h00);
    checks++; if (st_rdata !== 8'h00) begin errors++; $display("FAIL rm_cleared sel=%0d got %h exp 00", sel, st_rdata); end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      sel   = s;
      cur_l = (s == 0) ? 2 : (s == 1) ? 1 : 4;
      cur_d = (s == 0) ? 16 : 12;
      test_reset();
      test_read_timing();
      test_write_read();
      test_masked();
      if (cur_d == 12) test_out_of_range();
      test_back_to_back();
      test_reset_mid_access();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
